// File: rtl/macro_phase_sched.sv
// CIM macro phase sequencer: each accepted data_e runs LATCH -> CONV -> READ,
// driving latch/adc/macro_e, then advances the channel-group select.
module macro_phase_sched #(
  parameter int NUM_GROUPS = 4,
  parameter int LATCH_CYC  = 4,
  parameter int CONV_CYC   = 1,
  parameter int READ_CYC   = 3,
  parameter int ARM_CNT    = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          vs,
  input  logic                          data_e,
  output logic                          latch,
  output logic                          adc,
  output logic                          macro_e,
  output logic [$clog2(NUM_GROUPS)-1:0] chs_macro,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  // state | meaning
  // IDLE  | waiting for an accepted data_e
  // LATCH | latch high, adc low
  // CONV  | adc low while the macro converts
  // READ  | adc released, results read out; done on final cycle
  typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_CONV, ST_READ} state_t;

  localparam int GW    = $clog2(NUM_GROUPS);
  localparam int MAX_A = (LATCH_CYC > CONV_CYC) ? LATCH_CYC : CONV_CYC;
  localparam int MAX_C = (MAX_A > READ_CYC) ? MAX_A : READ_CYC;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam int AW    = $clog2(ARM_CNT + 2);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] chs_q, chs_d;
  logic [AW-1:0] arm_q, arm_d;
  logic          seq_armed_q, seq_armed_d;
  logic          ovr_q, ovr_d;
  logic          latch_q, latch_d;
  logic          adc_q, adc_d;
  logic          macro_e_q, macro_e_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last_read;
  logic          start;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chs_d       = chs_q;
    arm_d       = arm_q;
    seq_armed_d = seq_armed_q;
    ovr_d       = ovr_q;
    last_read   = (state_q == ST_READ) && (cnt_q == '0);
    start       = mode && data_e && !vs && ((state_q == ST_IDLE) || last_read);

    if (vs) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      chs_d   = '0;
      ovr_d   = 1'b0;
    end else if (!mode) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      if (data_e && !start) ovr_d = 1'b1;
      case (state_q)
        ST_LATCH: begin
          if (cnt_q == '0) begin
            state_d = ST_CONV;
            cnt_d   = CW'(CONV_CYC - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_CONV: begin
          if (cnt_q == '0) begin
            state_d = ST_READ;
            cnt_d   = CW'(READ_CYC - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_READ: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            chs_d   = chs_q + GW'(1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
      // Arm status is frozen per sequence so a start never arms itself mid-flight.
      if (start) begin
        state_d     = ST_LATCH;
        cnt_d       = CW'(LATCH_CYC - 1);
        seq_armed_d = (arm_q == AW'(ARM_CNT));
        if (arm_q != AW'(ARM_CNT)) arm_d = arm_q + AW'(1);
      end
    end

    latch_d   = (state_d == ST_LATCH);
    adc_d     = !((state_d == ST_LATCH) || (state_d == ST_CONV));
    busy_d    = (state_d != ST_IDLE);
    macro_e_d = busy_d && seq_armed_d;
    done_d    = (state_d == ST_READ) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      chs_q       <= '0;
      arm_q       <= '0;
      seq_armed_q <= 1'b0;
      ovr_q       <= 1'b0;
      latch_q     <= 1'b0;
      adc_q       <= 1'b1;
      macro_e_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chs_q       <= chs_d;
      arm_q       <= arm_d;
      seq_armed_q <= seq_armed_d;
      ovr_q       <= ovr_d;
      latch_q     <= latch_d;
      adc_q       <= adc_d;
      macro_e_q   <= macro_e_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign latch     = latch_q;
  assign adc       = adc_q;
  assign macro_e   = macro_e_q;
  assign chs_macro = chs_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_macro_phase_sched.sv
// Directed bench for macro_phase_sched: per-cycle expected outputs are queued as
// stimulus is driven and popped after each clock edge.
module tb_macro_phase_sched;

  logic clk = 1'b0;
  logic rst, mode, vs, data_e;
  logic latch, adc, macro_e, busy, done, overrun;
  logic [1:0] chs_macro;
  logic latch0, adc0, macro_e0, busy0, done0, overrun0;
  logic [1:0] chs0;

  always #5 clk = ~clk;

  macro_phase_sched dut (
    .clk(clk), .rst(rst), .mode(mode), .vs(vs), .data_e(data_e),
    .latch(latch), .adc(adc), .macro_e(macro_e), .chs_macro(chs_macro),
    .busy(busy), .done(done), .overrun(overrun)
  );

  macro_phase_sched #(.ARM_CNT(0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .vs(vs), .data_e(data_e),
    .latch(latch0), .adc(adc0), .macro_e(macro_e0), .chs_macro(chs0),
    .busy(busy0), .done(done0), .overrun(overrun0)
  );

  typedef struct {
    logic       latch;
    logic       adc;
    logic       me;
    logic       me0;
    logic       busy;
    logic       done;
    logic       ovr;
    logic [1:0] chs;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         starts = 0;
  logic [1:0] chs_m  = 2'd0;
  logic       ovr_m  = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.latch = 1'b0; e.adc = 1'b1; e.me = 1'b0; e.me0 = 1'b0;
      e.busy = 1'b0; e.done = 1'b0; e.ovr = ovr_m; e.chs = chs_m;
      exp_q.push_back(e);
    end
  endtask

  // n cycles of an accepted sequence; a full one (n=8) advances the group.
  task automatic push_seq(input int n);
    exp_t e;
    logic armed;
    armed = (starts >= 31);
    for (int k = 1; k <= n; k++) begin
      e.latch = (k <= 4); e.adc = (k > 5); e.me = armed; e.me0 = 1'b1;
      e.busy = 1'b1; e.done = (k == 8); e.ovr = ovr_m; e.chs = chs_m;
      exp_q.push_back(e);
    end
    starts++;
    if (n == 8) chs_m = chs_m + 2'd1;
  endtask

  task automatic check_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk("latch",   {7'd0, latch},    {7'd0, e.latch});
      chk("adc",     {7'd0, adc},      {7'd0, e.adc});
      chk("macro_e", {7'd0, macro_e},  {7'd0, e.me});
      chk("me_arm0", {7'd0, macro_e0}, {7'd0, e.me0});
      chk("busy",    {7'd0, busy},     {7'd0, e.busy});
      chk("done",    {7'd0, done},     {7'd0, e.done});
      chk("overrun", {7'd0, overrun},  {7'd0, e.ovr});
      chk("chs",     {6'd0, chs_macro}, {6'd0, e.chs});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  // Full 8-cycle sequence; the last tick observes the done cycle, so calling
  // this again immediately issues a back-to-back request.
  task automatic start_full();
    data_e = 1'b1;
    push_seq(8);
    tick();
    data_e = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; vs = 1'b0; data_e = 1'b0;
    #12;
    push_idle(1);
    check_now();
    @(negedge clk);
    rst = 1'b0; mode = 1'b1;
    push_idle(1);
    tick();

    // single sequence, then idle with group advanced
    start_full();
    push_idle(1);
    tick();

    // five back-to-back sequences
    repeat (5) start_full();
    push_idle(1);
    tick();

    // second request 3 cycles in is dropped and sets overrun
    data_e = 1'b1;
    push_seq(8);
    for (int i = exp_q.size() - 5; i < exp_q.size(); i++) exp_q[i].ovr = 1'b1;
    ovr_m = 1'b1;
    tick();
    data_e = 1'b0;
    tick();
    tick();
    data_e = 1'b1;
    tick();
    data_e = 1'b0;
    repeat (4) tick();
    push_idle(1);
    tick();
    // vs with a simultaneous request: cleared, request ignored
    vs = 1'b1; data_e = 1'b1;
    ovr_m = 1'b0; chs_m = 2'd0;
    push_idle(1);
    tick();
    vs = 1'b0; data_e = 1'b0;
    push_idle(1);
    tick();

    // vs five cycles into a sequence aborts it with no done
    data_e = 1'b1;
    push_seq(5);
    tick();
    data_e = 1'b0;
    repeat (4) tick();
    vs = 1'b1;
    chs_m = 2'd0;
    push_idle(1);
    tick();
    vs = 1'b0;

    // mode drop two cycles in: idle next cycle, group held
    start_full();
    data_e = 1'b1;
    push_seq(2);
    tick();
    data_e = 1'b0;
    tick();
    mode = 1'b0;
    push_idle(1);
    tick();
    data_e = 1'b1;
    push_idle(1);
    tick();
    data_e = 1'b0; mode = 1'b1;
    push_idle(1);
    tick();

    // run up to the arm threshold; start 32 is the first armed one
    while (starts < 31) start_full();
    start_full();
    push_idle(1);
    tick();

    // async reset mid-sequence clears outputs and arm counter immediately
    data_e = 1'b1;
    push_seq(3);
    tick();
    data_e = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    starts = 0; chs_m = 2'd0; ovr_m = 1'b0;
    push_idle(1);
    check_now();
    @(negedge clk);
    rst = 1'b0;
    start_full();
    push_idle(1);
    tick();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
